// File: rtl/uart_msg_seq_if.sv
// uart_msg_seq_if: byte stream handshake toward a UART transmitter
interface uart_msg_seq_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  modport master(output tx_data, tx_valid, input tx_ready);
  modport slave(input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/uart_msg_seq.sv
// uart_msg_seq: periodic "CH<d>:HHHH\r\n" message generator carrying the completed-message count
module uart_msg_seq #(
  parameter int CHANNEL    = 0,
  parameter int GAP_CYCLES = 1000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  uart_msg_seq_if.master tx,
  output logic           busy,
  output logic [15:0]    msg_count
);
  typedef enum logic [1:0] {IDLE, GAP, SEND} state_t;
  state_t      state, state_n;
  logic [19:0] gap_cnt;
  logic [3:0]  idx, idx_n, nib;
  logic [15:0] snap;
  logic [7:0]  hex, nxt_byte;
  logic        xfer, last, gap_done;
  always_comb begin
    xfer     = state == SEND && tx.tx_valid && tx.tx_ready;
    last     = xfer && idx == 4'd9;
    gap_done = gap_cnt == 20'(GAP_CYCLES);
    state_n  = state == IDLE ? (enable ? GAP : IDLE) :
               state == GAP  ? (!enable ? IDLE : gap_done ? SEND : GAP) :
               last          ? (enable ? GAP : IDLE) : SEND;
  end
  // next byte is built from the snapshot so count updates never leak into a message
  always_comb begin
    idx_n    = idx + 4'd1;
    nib      = idx_n == 4'd4 ? snap[15:12] : idx_n == 4'd5 ? snap[11:8] :
               idx_n == 4'd6 ? snap[7:4]   : snap[3:0];
    hex      = nib < 4'd10 ? {4'h3, nib} : {4'h0, nib} + 8'h37;
    nxt_byte = idx_n == 4'd1 ? 8'h48 : idx_n == 4'd2 ? 8'h30 + 8'(CHANNEL) :
               idx_n == 4'd3 ? 8'h3A : idx_n <= 4'd7 ? hex :
               idx_n == 4'd8 ? 8'h0D : 8'h0A;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt     <= '0;
      idx         <= '0;
      snap        <= '0;
      msg_count   <= '0;
      tx.tx_valid <= 1'b0;
      tx.tx_data  <= '0;
    end else begin
      gap_cnt <= state == GAP ? gap_cnt + 20'd1 : 20'd0;
      if (state == GAP && state_n == SEND) begin
        tx.tx_valid <= 1'b1;
        tx.tx_data  <= 8'h43;
        idx         <= '0;
        snap        <= msg_count;
      end else if (last) begin
        tx.tx_valid <= 1'b0;
        tx.tx_data  <= '0;
        idx         <= '0;
        msg_count   <= msg_count + 16'd1;
      end else if (xfer) begin
        tx.tx_data <= nxt_byte;
        idx        <= idx_n;
      end
    end
  end
  assign busy = state == SEND;
endmodule

// File: tb/tb_uart_msg_seq.sv
// tb_uart_msg_seq: scoreboard bench for uart_msg_seq with CHANNEL=3, GAP_CYCLES=4
module tb_uart_msg_seq;
  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, busy;
  logic [15:0] msg_count;
  logic [7:0]  exp_q[$];
  logic [7:0]  held;
  logic        bp = 1'b0, stall_prev = 1'b0;
  int          tests = 0, fails = 0, xfers = 0, ph = 0, k, seen, run, base;

  uart_msg_seq_if bus();
  uart_msg_seq #(.CHANNEL(3), .GAP_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .tx(bus), .busy(busy), .msg_count(msg_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hx(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + 8'(n) : 8'h41 + 8'(n) - 8'd10;
  endfunction

  task automatic push_msg(input logic [15:0] v);
    exp_q.push_back(8'h43); exp_q.push_back(8'h48); exp_q.push_back(8'h33); exp_q.push_back(8'h3A);
    exp_q.push_back(hx(v[15:12])); exp_q.push_back(hx(v[11:8]));
    exp_q.push_back(hx(v[7:4]));   exp_q.push_back(hx(v[3:0]));
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
  endtask

  task automatic wait_xfers(input int target);
    for (int i = 0; i < 400 && xfers < target; i++) @(posedge clk);
    #2;
    chk("xfer_timeout", xfers >= target, 1);
  endtask

  task automatic first_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tx_valid && n < 50);
  endtask

  task automatic quiet(input int n, output int s);
    s = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.tx_valid) s++;
    end
  endtask

  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_ready = bp ? (ph == 0 || ph == 3) : 1'b1;
      ph = (ph + 1) % 4;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) stall_prev = 1'b0;
      else begin
        chk("busy_vs_valid", busy, bus.tx_valid);
        if (stall_prev) begin
          chk("stall_hold_valid", bus.tx_valid, 1);
          chk("stall_hold_data", bus.tx_data, held);
        end
        if (bus.tx_valid && bus.tx_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_byte: got %02h expected none", bus.tx_data);
          end else chk("byte", bus.tx_data, exp_q.pop_front());
          xfers++;
        end
        stall_prev = bus.tx_valid && !bus.tx_ready;
        held = bus.tx_data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.tx_valid, 0);
    chk("rst_data", bus.tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", msg_count, 0);
    rst_n = 1'b1;
    quiet(6, seen);
    chk("idle_without_enable", seen, 0);
    // basic message, back-to-back
    push_msg(16'h0000);
    enable = 1'b1;
    first_valid(k);
    chk("first_latency", k, 6);
    run = 1;
    repeat (9) begin
      @(negedge clk);
      if (bus.tx_valid) run++;
    end
    chk("back_to_back", run, 10);
    @(negedge clk);
    chk("valid_drop", bus.tx_valid, 0);
    chk("count_1", msg_count, 1);
    enable = 1'b0;
    quiet(8, seen);
    chk("gap_abort_quiet", seen, 0);
    // backpressure 1,0,0,1
    bp = 1'b1;
    push_msg(16'h0001);
    base = xfers;
    enable = 1'b1;
    wait_xfers(base + 10);
    enable = 1'b0;
    bp = 1'b0;
    chk("count_2", msg_count, 2);
    quiet(8, seen);
    // enable dropped during SEND
    push_msg(16'h0002);
    base = xfers;
    enable = 1'b1;
    wait_xfers(base + 2);
    enable = 1'b0;
    chk("busy_mid_send", busy, 1);
    wait_xfers(base + 10);
    chk("idle_after_send", busy, 0);
    chk("count_3", msg_count, 3);
    quiet(10, seen);
    chk("no_valid_disabled", seen, 0);
    // enable dropped during GAP, then a full gap on re-enable
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    enable = 1'b0;
    quiet(8, seen);
    chk("gap_drop_quiet", seen, 0);
    push_msg(16'h0003);
    base = xfers;
    enable = 1'b1;
    first_valid(k);
    chk("regap_latency", k, 6);
    wait_xfers(base + 10);
    enable = 1'b0;
    chk("count_4", msg_count, 4);
    quiet(8, seen);
    // hex letters and wrap
    force dut.msg_count = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.msg_count;
    chk("count_forced", msg_count, 16'hFFFE);
    push_msg(16'hFFFE);
    push_msg(16'hFFFF);
    push_msg(16'h0000);
    base = xfers;
    @(negedge clk);
    enable = 1'b1;
    wait_xfers(base + 10);
    chk("count_ffff", msg_count, 16'hFFFF);
    wait_xfers(base + 20);
    chk("count_wrap", msg_count, 16'h0000);
    wait_xfers(base + 30);
    enable = 1'b0;
    chk("count_after_wrap", msg_count, 16'h0001);
    quiet(8, seen);
    // asynchronous reset at byte index 5
    push_msg(16'h0001);
    base = xfers;
    enable = 1'b1;
    wait_xfers(base + 5);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.tx_valid, 0);
    chk("arst_data", bus.tx_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_count", msg_count, 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    push_msg(16'h0000);
    base = xfers;
    first_valid(k);
    chk("post_rst_latency", k, 6);
    wait_xfers(base + 10);
    enable = 1'b0;
    chk("post_rst_count", msg_count, 1);
    quiet(5, seen);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_msg_seq.md
UART_MSG_SEQ -- requirements
Module: uart_msg_seq

Interface
REQ-001 Parameter CHANNEL, default 0: channel digit, 0..9, sent as ASCII '0'+CHANNEL.
REQ-002 Parameter GAP_CYCLES, default 1000: idle clocks between messages, legal range 1..2^20-1.
REQ-003 Port clk  input  1: single clock; all state on rising edge.
REQ-004 Port rst_n  input  1: asynchronous, active-low reset.
REQ-005 Port enable  input  1: high permits new messages to start.
REQ-006 Port tx_data  output  8: byte offered to the downstream UART transmitter.
REQ-007 Port tx_valid  output  1: tx_data holds a valid byte.
REQ-008 Port tx_ready  input  1: downstream accepts a byte this cycle.
REQ-009 Port busy  output  1: high while a message is in progress (state SEND).
REQ-010 Port msg_count  output  16: number of completed messages, wraps.

Function
REQ-011 The message SHALL be 10 bytes: 'C','H',digit,':',H3,H2,H1,H0,0x0D,0x0A.
- H3..H0: uppercase ASCII hex of the snapshot, MS nibble first ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46).
REQ-012 The FSM SHALL have three states:
- IDLE: enable low.
- GAP: counting the inter-message gap.
- SEND: presenting message bytes.
REQ-013 IDLE -> GAP when enable = 1; the gap counter clears on entry.
REQ-014 GAP SHALL count GAP_CYCLES clocks; GAP -> SEND on the cycle after the count completes. In the same edge:
- snapshot <= msg_count
- byte index <= 0
REQ-015 In SEND, tx_valid = 1 and tx_data = byte[index], both registered.
REQ-016 A transfer occurs on a rising edge with tx_valid & tx_ready = 1; index increments on transfer only.
REQ-017 While tx_valid = 1 and tx_ready = 0, tx_data and tx_valid SHALL hold stable (AXI-style, no withdrawal).
REQ-018 Back-to-back transfers SHALL be supported: with tx_ready held high, one byte per clock, 10 consecutive cycles.
REQ-019 Transfer of byte index 9 (0x0A) SHALL, on the same edge:
- increment msg_count modulo 2^16 (0xFFFF -> 0x0000)
- drop tx_valid to 0 on the following cycle
- enter GAP if enable = 1, else IDLE
REQ-020 Deasserting enable during SEND SHALL NOT abort the message; the message completes, then the FSM enters IDLE.
REQ-021 Deasserting enable during GAP SHALL return the FSM to IDLE next cycle; the gap counter is discarded.
REQ-022 Message content SHALL use the snapshot only; msg_count updates are not visible until the next message.
REQ-023 busy SHALL equal (state == SEND); tx_valid SHALL be 0 in IDLE and GAP.
REQ-024 tx_ready SHALL be ignored outside SEND.

Reset
REQ-025 rst_n low SHALL immediately force, regardless of clk, including mid-message:
- state IDLE
- tx_valid 0, tx_data 0x00, busy 0
- msg_count 0x0000, gap counter 0, index 0, snapshot 0
REQ-026 After rst_n rises, the first message SHALL NOT start until enable = 1 and a full gap has elapsed.
REQ-027 A message interrupted by reset is lost and not counted.

Verification
REQ-028 Basic message: CHANNEL=3, GAP_CYCLES=4, enable=1, tx_ready=1 after reset.
- First byte appears 5 cycles after enable is sampled.
- Stream: 43 48 33 3A 30 30 30 30 0D 0A in 10 consecutive cycles.
- msg_count = 1 afterwards.
REQ-029 Backpressure: tx_ready pattern 1,0,0,1 repeating.
- tx_data/tx_valid stable across every stalled cycle.
- Byte order unchanged; no duplicates or drops.
REQ-030 Hex and wrap: msg_count advanced to 0xFFFE (force or long run).
- Messages carry "FFFE" then "FFFF", then the next carries "0000".
- msg_count = 0x0000 after the FFFF message.
REQ-031 Enable during SEND: enable dropped at byte index 2.
- All 10 bytes still sent; FSM enters IDLE; no further tx_valid while enable = 0.
REQ-032 Enable during GAP: enable dropped mid-gap.
- FSM enters IDLE; on re-enable, a full GAP_CYCLES gap elapses before the next message.
REQ-033 Reset mid-message: rst_n pulsed low at byte index 5, asynchronously between edges.
- tx_valid = 0 and msg_count = 0 immediately.
- Next message restarts at 'C' with "0000".
